mux_sel_sequencer: RTL and testbench
====================================

// Module: mux_sel_sequencer
// PURPOSE
//   Upstream control stage for the 4-to-1 mux: steps the mux select through channels 0..3.
//   Holds each channel for a programmable dwell time, in one-shot or continuous mode.
//   Flags when the select is valid and pulses done at the end of every full sweep.
//   Optionally samples the mux output g into a 4-bit result word.
// PARAMETERS
//   DWELL_W   4   width of dwell input; dwell range 0..2**DWELL_W-1
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous, active-low reset
//   start      in   1        begin sweep (honoured only in IDLE)
//   stop       in   1        abort sweep, return to IDLE
//   mode       in   1        0 = one-shot, 1 = continuous; latched on accepted start
//   dwell      in   DWELL_W  cycles per channel; latched on accepted start; 0 treated as 1
//   sel        out  2        mux select, drives mux4to1.sel
//   sel_valid  out  1        high while sel is being driven in RUN
//   busy       out  1        high in RUN and DONE
//   done       out  1        one-cycle pulse at end of each full sweep 0..3
//   g          in   1        mux output (CAPTURE_EN only)
//   result     out  4        result[k] = g sampled on channel k (CAPTURE_EN only)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; sel=0; sel_valid=0; busy=0; done=0; result=0; dwell cnt=0.
//   States: IDLE, RUN, DONE.
//   IDLE: start=1 and stop=0 -> RUN at next edge.
//     Latch mode and max(dwell,1) into D; sel=0; cnt=0; sel_valid=1; busy=1.
//   RUN: each cycle cnt++; when cnt==D-1 this is the channel's last cycle.
//     Last cycle, sel<3: sel++ and cnt=0 at next edge.
//     Last cycle, sel==3, one-shot: -> DONE; sel_valid=0; done=1 in DONE.
//     Last cycle, sel==3, continuous: sel wraps to 0 at next edge; stays in RUN.
//       done=1 for the first cycle of the new sweep (same pulse timing as one-shot).
//     Each channel is held exactly D cycles; one-shot sweep = 4*D cycles of sel_valid.
//   DONE: lasts one cycle; busy=1, done=1; -> IDLE. start here is ignored.
//   stop=1 in RUN or DONE: -> IDLE next edge; sel=0; sel_valid=0; busy=0.
//     A sweep aborted from RUN produces no done pulse.
//     stop aborts DONE but does not suppress its done pulse.
//   Simultaneous start and stop in IDLE: stop wins, stay IDLE.
//   start while busy: ignored; dwell/mode changes mid-sweep have no effect.
//   Outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   MUX_SEQ_CAPTURE_EN defined:
//     g sampled on the last dwell cycle of channel k into result[k].
//     Sampling is late in the dwell so the mux output has settled.
//     result holds its value until the next accepted start, which clears it to 0.
//   MUX_SEQ_CAPTURE_EN undefined:
//     g and result ports absent; no capture logic.
// STRUCTURE
//   Shared header mux_seq_defs.vh (`define constants):
//     state codes ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//     MODE_ONESHOT=1'b0, MODE_CONT=1'b1
//     NUM_CH=4
//   Sub-module dwell_counter:
//     load/enable inputs, terminal-count output at cnt==D-1, with D held inside.
//   The top level contains the FSM, the sel counter and the capture register.
// TESTING (bench instantiates mux4to1 with sel driven by this block; j=4'b1110)
//   1. rst_n low mid-cycle -> all outputs 0 immediately (async, before next edge).
//   2. One-shot, dwell=2, start pulse
//      -> sel 0,0,1,1,2,2,3,3 with sel_valid=1.
//      -> done=1 on the cycle after the last sel=3 cycle.
//      -> with CAPTURE_EN, result=4'b1110.
//   3. One-shot, dwell=0 -> each channel held 1 cycle; done 5 cycles after start is accepted.
//   4. Continuous, dwell=1, run 10 cycles
//      -> sel 0,1,2,3,0,1,...
//      -> done pulses with the 2nd and 3rd sel=0 cycles; busy stays 1.
//   5. stop during sel=2 -> IDLE next edge, sel=0, busy=0, no done; new start restarts at sel=0.
//   6. start and stop high together in IDLE -> stays IDLE.
//      Then rst_n low during RUN -> immediate IDLE, outputs 0.

Source files
------------

// File: rtl/mux_sel_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer_pkg
//   Shared definitions for the mux select sequencer:
//     state_t       FSM state codes (IDLE=0, RUN=1, DONE=2)
//     MODE_ONESHOT  single sweep 0..3, then DONE
//     MODE_CONT     sweeps repeat until stop
//     NUM_CH        number of mux channels swept
//     LAST_CH       select value of the final channel in a sweep
// ---------------------------------------------------------------------------
package mux_sel_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_CONT    = 1'b1;

   localparam int         NUM_CH  = 4;
   localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

endpackage

// File: rtl/mux_sel_sequencer_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
//   Counts the cycles a channel has been held. The dwell length D is captured
//   on load (a dwell of 0 is stored as 1) and held until the next load.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        capture dwell into D and restart the count at 0
//     en          advance the count (the sequencer is in RUN)
//     dwell       requested cycles per channel
//     tc          terminal count: high while cnt == D-1 (channel's last cycle)
// ---------------------------------------------------------------------------
module dwell_counter
   import mux_sel_sequencer_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   output logic               tc
);

   logic [DWELL_W-1:0] d_q;
   logic [DWELL_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q   <= DWELL_W'(1);
         cnt_q <= '0;
      end else if (load) begin
         d_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
         cnt_q <= '0;
      end else if (en) begin
         // wrap on the last cycle so the next channel starts from 0
         cnt_q <= tc ? '0 : cnt_q + DWELL_W'(1);
      end else begin
         cnt_q <= '0;
      end
   end

   // D is never 0, so D-1 cannot underflow
   assign tc = (cnt_q == (d_q - DWELL_W'(1)));

endmodule

// File: rtl/mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer
//   Steps a 4-to-1 mux select through channels 0..3, holding each channel for
//   a programmable dwell time, in one-shot or continuous mode. done pulses
//   for one cycle at the end of every complete sweep.
//
//   Optional feature macro: MUX_SEQ_CAPTURE_EN
//     When defined, the mux output g is sampled on the last dwell cycle of
//     channel k into result[k]; result is cleared by each accepted start.
//     When undefined, the g and result ports and the capture logic are absent.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     start       begin a sweep (honoured only in IDLE, and only if stop=0)
//     stop        abort, return to IDLE (wins over start)
//     mode        0 one-shot, 1 continuous; latched on accepted start
//     dwell       cycles per channel; latched on accepted start; 0 acts as 1
//     sel         mux select
//     sel_valid   high in RUN
//     busy        high in RUN and DONE
//     done        one-cycle pulse at the end of each full sweep
//     g, result   capture input / result word (MUX_SEQ_CAPTURE_EN only)
//     state_dbg   current FSM state code
//
//   Handshake: start is a level sampled on the clock edge; it is accepted only
//   when the block is in IDLE and stop is low, and is silently dropped
//   otherwise. All outputs come from registers; none depend combinationally
//   on the inputs.
// ---------------------------------------------------------------------------
module mux_sel_sequencer
   import mux_sel_sequencer_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   output logic [1:0]         sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               done,
`ifdef MUX_SEQ_CAPTURE_EN
   input  logic               g,
   output logic [3:0]         result,
`endif
   output logic [1:0]         state_dbg
);

   state_t     state_q;
   state_t     state_n;
   logic [1:0] sel_n;
   logic       done_n;
   logic       mode_q;
   logic       load;
   logic       tc;
   logic       cnt_en;

   dwell_counter #(
      .DWELL_W (DWELL_W)
   ) u_dwell_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .en    (cnt_en),
      .dwell (dwell),
      .tc    (tc)
   );

   assign cnt_en = (state_q == ST_RUN);

   // ---------------- state and output registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel     <= 2'd0;
         done    <= 1'b0;
         mode_q  <= MODE_ONESHOT;
      end else begin
         state_q <= state_n;
         sel     <= sel_n;
         done    <= done_n;
         if (load) begin
            mode_q <= mode;
         end
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_n = state_q;
      sel_n   = sel;
      done_n  = 1'b0;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sel_n = 2'd0;
            if (start && !stop) begin
               state_n = ST_RUN;
               load    = 1'b1;
            end
         end

         ST_RUN: begin
            if (stop) begin
               // aborted sweeps never produce done
               state_n = ST_IDLE;
               sel_n   = 2'd0;
            end else if (tc) begin
               if (sel == LAST_CH) begin
                  sel_n  = 2'd0;
                  done_n = 1'b1;
                  // continuous mode wraps in place; done lands on the first
                  // cycle of the next sweep, same timing as the DONE state
                  if (mode_q == MODE_ONESHOT) begin
                     state_n = ST_DONE;
                  end
               end else begin
                  sel_n = sel + 2'd1;
               end
            end
         end

         ST_DONE: begin
            // single-cycle state; stop here has the same effect as not
            state_n = ST_IDLE;
            sel_n   = 2'd0;
         end

         default: begin
            state_n = ST_IDLE;
            sel_n   = 2'd0;
         end
      endcase
   end

   assign sel_valid = (state_q == ST_RUN);
   assign busy      = (state_q != ST_IDLE);
   assign state_dbg = state_q;

`ifdef MUX_SEQ_CAPTURE_EN
   // Sample on the channel's last dwell cycle so the mux output has settled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 4'd0;
      end else if (load) begin
         result <= 4'd0;
      end else if ((state_q == ST_RUN) && tc) begin
         result[sel] <= g;
      end
   end
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_sequencer
//   Bench for mux_sel_sequencer. A behavioural 4-to-1 mux with j=4'b1110
//   feeds g when MUX_SEQ_CAPTURE_EN is defined. Each vector row drives one
//   cycle of inputs and the outputs expected after the following clock edge.
// ---------------------------------------------------------------------------
module tb_mux_sel_sequencer;

   localparam int DWELL_W = 4;
   localparam int W       = 5;   // {sel[1:0], sel_valid, busy, done}

   // ---------------- clock / reset ----------------
   logic               clk   = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               stop  = 1'b0;
   logic               mode  = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [1:0]         sel;
   logic               sel_valid;
   logic               busy;
   logic               done;
   logic [1:0]         state_dbg;
`ifdef MUX_SEQ_CAPTURE_EN
   logic [3:0]         j = 4'b1110;
   logic               g;
   logic [3:0]         result;
   assign g = j[sel];
`endif

   always #5 clk = ~clk;

   mux_sel_sequencer #(
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode      (mode),
      .dwell     (dwell),
      .sel       (sel),
      .sel_valid (sel_valid),
      .busy      (busy),
      .done      (done),
`ifdef MUX_SEQ_CAPTURE_EN
      .g         (g),
      .result    (result),
`endif
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int           n_vec  = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic               start;
      logic               stop;
      logic               mode;
      logic [DWELL_W-1:0] dwell;
      logic [W-1:0]       exp;
      logic               chk_res;
      logic [3:0]         res;
      string              name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic st, input logic sp, input logic md,
                               input logic [DWELL_W-1:0] dw, input logic [1:0] s,
                               input logic v, input logic b, input logic d,
                               input string nm, input logic cr = 1'b0,
                               input logic [3:0] r = 4'd0);
      vec_t x;
      x.start   = st;
      x.stop    = sp;
      x.mode    = md;
      x.dwell   = dw;
      x.exp     = {s, v, b, d};
      x.chk_res = cr;
      x.res     = r;
      x.name    = nm;
      vecs.push_back(x);
   endfunction

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: {sel,sel_valid,busy,done} got %b expected %b", nm, act, expv);
      end
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: drive one cycle, then compare after the next posedge.
   task automatic apply(input vec_t v);
      logic [W-1:0] e;
      start = v.start;
      stop  = v.stop;
      mode  = v.mode;
      dwell = v.dwell;
      exp_q.push_back(v.exp);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check(v.name, {sel, sel_valid, busy, done}, e);
`ifdef MUX_SEQ_CAPTURE_EN
      if (v.chk_res) begin
         n_vec++;
         if (result !== v.res) begin
            n_fail++;
            $display("FAIL %s result: got %b expected %b", v.name, result, v.res);
         end
      end
`endif
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
      end
      vecs.delete();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test ----------------
   initial begin
      // reset state while rst_n is held low
      #2;
      check("reset_outputs", {sel, sel_valid, busy, done}, '0);
      n_vec++;
      if (state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected 0", state_dbg);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // one-shot, dwell=2; start mid-sweep with other mode/dwell is ignored
      add(1, 0, 0, 2, 0, 1, 1, 0, "os2_start");
      add(0, 0, 0, 2, 0, 1, 1, 0, "os2_ch0b");
      add(0, 0, 0, 2, 1, 1, 1, 0, "os2_ch1a");
      add(1, 0, 1, 7, 1, 1, 1, 0, "os2_busy_start");
      add(0, 0, 0, 2, 2, 1, 1, 0, "os2_ch2a");
      add(0, 0, 0, 2, 2, 1, 1, 0, "os2_ch2b");
      add(0, 0, 0, 2, 3, 1, 1, 0, "os2_ch3a");
      add(0, 0, 0, 2, 3, 1, 1, 0, "os2_ch3b");
      add(0, 0, 0, 2, 0, 0, 1, 1, "os2_done");
      add(0, 0, 0, 2, 0, 0, 0, 0, "os2_idle", 1, 4'b1110);

      // one-shot, dwell=0 acts as 1; accepted start clears result
      add(1, 0, 0, 0, 0, 1, 1, 0, "os0_start", 1, 4'b0000);
      add(0, 0, 0, 0, 1, 1, 1, 0, "os0_ch1");
      add(0, 0, 0, 0, 2, 1, 1, 0, "os0_ch2");
      add(0, 0, 0, 0, 3, 1, 1, 0, "os0_ch3");
      add(0, 0, 0, 0, 0, 0, 1, 1, "os0_done");
      add(0, 0, 0, 0, 0, 0, 0, 0, "os0_idle", 1, 4'b1110);

      // continuous, dwell=1: done with 2nd and 3rd sel=0
      add(1, 0, 1, 1, 0, 1, 1, 0, "ct_start");
      add(0, 0, 1, 1, 1, 1, 1, 0, "ct_1");
      add(0, 0, 1, 1, 2, 1, 1, 0, "ct_2");
      add(0, 0, 1, 1, 3, 1, 1, 0, "ct_3");
      add(0, 0, 1, 1, 0, 1, 1, 1, "ct_wrap1");
      add(0, 0, 1, 1, 1, 1, 1, 0, "ct_5");
      add(0, 0, 1, 1, 2, 1, 1, 0, "ct_6");
      add(0, 0, 1, 1, 3, 1, 1, 0, "ct_7");
      add(0, 0, 1, 1, 0, 1, 1, 1, "ct_wrap2");
      add(0, 0, 1, 1, 1, 1, 1, 0, "ct_9");
      add(0, 1, 1, 1, 0, 0, 0, 0, "ct_stop");

      // stop during sel=2, then restart from sel=0
      add(1, 0, 0, 1, 0, 1, 1, 0, "ab_start");
      add(0, 0, 0, 1, 1, 1, 1, 0, "ab_1");
      add(0, 0, 0, 1, 2, 1, 1, 0, "ab_2");
      add(0, 1, 0, 1, 0, 0, 0, 0, "ab_stop");
      add(0, 0, 0, 1, 0, 0, 0, 0, "ab_idle");
      add(1, 0, 0, 1, 0, 1, 1, 0, "ab_restart");
      add(0, 0, 0, 1, 1, 1, 1, 0, "ab_r1");
      add(0, 0, 0, 1, 2, 1, 1, 0, "ab_r2");
      add(0, 0, 0, 1, 3, 1, 1, 0, "ab_r3");
      add(0, 0, 0, 1, 0, 0, 1, 1, "ab_done");
      add(0, 0, 0, 1, 0, 0, 0, 0, "ab_idle2");

      // stop on the final cycle of sel=3: no done pulse
      add(1, 0, 0, 1, 0, 1, 1, 0, "l3_start");
      add(0, 0, 0, 1, 1, 1, 1, 0, "l3_1");
      add(0, 0, 0, 1, 2, 1, 1, 0, "l3_2");
      add(0, 0, 0, 1, 3, 1, 1, 0, "l3_3");
      add(0, 1, 0, 1, 0, 0, 0, 0, "l3_stop_nodone");

      // stop while in DONE: pulse already out, back to IDLE
      add(1, 0, 0, 1, 0, 1, 1, 0, "sd_start");
      add(0, 0, 0, 1, 1, 1, 1, 0, "sd_1");
      add(0, 0, 0, 1, 2, 1, 1, 0, "sd_2");
      add(0, 0, 0, 1, 3, 1, 1, 0, "sd_3");
      add(0, 0, 0, 1, 0, 0, 1, 1, "sd_done");
      add(0, 1, 0, 1, 0, 0, 0, 0, "sd_stop_idle");

      // start and stop together in IDLE: stop wins
      add(1, 1, 0, 1, 0, 0, 0, 0, "ss_both");
      add(0, 0, 0, 1, 0, 0, 0, 0, "ss_idle");

      // maximum dwell: 15 cycles per channel, 60 cycles of sel_valid
      for (int i = 0; i < 60; i++) begin
         add((i == 0) ? 1'b1 : 1'b0, 0, 0, 15, 2'(i / 15), 1, 1, 0, "max_dwell");
      end
      add(0, 0, 0, 15, 0, 0, 1, 1, "max_done");
      add(0, 0, 0, 15, 0, 0, 0, 0, "max_idle", 1, 4'b1110);

      run_table();

      // asynchronous reset in the middle of a continuous RUN
      add(1, 0, 1, 3, 0, 1, 1, 0, "rr_start");
      add(0, 0, 1, 3, 0, 1, 1, 0, "rr_0b");
      add(0, 0, 1, 3, 0, 1, 1, 0, "rr_0c");
      add(0, 0, 1, 3, 1, 1, 1, 0, "rr_1a");
      run_table();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_run", {sel, sel_valid, busy, done}, '0);
      n_vec++;
      if (state_dbg !== 2'd0) begin
         n_fail++;
         $display("FAIL async_reset_state: got %0d expected 0", state_dbg);
      end
`ifdef MUX_SEQ_CAPTURE_EN
      n_vec++;
      if (result !== 4'd0) begin
         n_fail++;
         $display("FAIL async_reset_result: got %b expected 0000", result);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // normal operation after reset
      add(1, 0, 0, 0, 0, 1, 1, 0, "pr_start");
      add(0, 0, 0, 0, 1, 1, 1, 0, "pr_1");
      run_table();

      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
